// File: rtl/wide_uart_tx.sv
// wide_uart_tx: UART transmitter with a one-word holding buffer.
// Frame: start bit (0), DATA_BITS data bits, stop bit (1), DIV clocks each.
// Optional build macro WIDE_UART_TX_BITREV_EN: send data MSB first
// (default build sends LSB first).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle high, shifter empty
// START | start bit (0) on the line
// DATA  | data bits shifted out, r_bit_cnt = bits remaining after this one
// STOP  | stop bit (1); next frame follows immediately if a word is waiting
module wide_uart_tx #(
    parameter int BAUD_RATE    = 8000000,
    parameter int SYS_CLK_FREQ = 128000000,
    parameter int DATA_BITS    = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 transmit,
    input  logic [DATA_BITS-1:0] tx_word,
    output logic                 tx,
    output logic                 tx_ready,
    output logic                 is_transmitting,
    output logic                 tx_done
);
    localparam int DIV = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [BW-1:0] BITS_M1 = BW'(DATA_BITS - 1);

    if (((SYS_CLK_FREQ % BAUD_RATE) != 0) || (DIV < 2)) begin : g_bad_div
        $error("wide_uart_tx: SYS_CLK_FREQ/BAUD_RATE must be an integer >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state,    w_state_nxt;
    logic [CW-1:0]        r_baud_cnt, w_baud_nxt;
    logic [BW-1:0]        r_bit_cnt,  w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic [DATA_BITS-1:0] r_buf,      w_buf_nxt;
    logic                 r_buf_full, w_buf_full_nxt;
    logic                 r_tx,       w_tx_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_done,     w_done_nxt;
    logic [DATA_BITS-1:0] w_word_ord;
    logic                 w_accept;
    logic                 w_baud_end;

    assign w_accept   = transmit & ~r_buf_full;
    assign w_baud_end = (r_baud_cnt == '0);

    // Put the incoming word in line order so the shifter always sends bit 0 first.
    always_comb begin
        w_word_ord = '0;
`ifdef WIDE_UART_TX_BITREV_EN
        for (int i = 0; i < DATA_BITS; i++) begin
            w_word_ord[i] = tx_word[DATA_BITS-1-i];
        end
`else
        w_word_ord = tx_word;
`endif
    end

    // Next-state, datapath and registered-output values.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_nxt     = r_baud_cnt;
        w_bit_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_buf_nxt      = r_buf;
        w_buf_full_nxt = r_buf_full;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        if ((r_state != IDLE) && !w_baud_end) begin
            w_baud_nxt = r_baud_cnt - CW'(1);
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_nxt = w_word_ord;
                    w_state_nxt = START;
                    w_tx_nxt    = 1'b0;
                    w_baud_nxt  = DIV_M1;
                    w_busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (w_baud_end) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = BITS_M1;
                    w_baud_nxt  = DIV_M1;
                end
            end
            DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = DIV_M1;
                    if (r_bit_cnt == '0) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                        w_bit_nxt   = r_bit_cnt - BW'(1);
                    end
                end
            end
            STOP: begin
                // Registered one cycle early so the pulse lands on the last stop clock.
                w_done_nxt = (r_baud_cnt == CW'(1));
                if (w_baud_end) begin
                    if (r_buf_full) begin
                        w_shift_nxt    = r_buf;
                        w_buf_full_nxt = 1'b0;
                        w_state_nxt    = START;
                        w_tx_nxt       = 1'b0;
                        w_baud_nxt     = DIV_M1;
                    end else if (transmit) begin
                        w_shift_nxt = w_word_ord;
                        w_state_nxt = START;
                        w_tx_nxt    = 1'b0;
                        w_baud_nxt  = DIV_M1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // While busy, an accepted word parks in the buffer, except on the
        // final stop edge where it goes straight into the shifter above.
        if (w_accept && (r_state != IDLE) && !((r_state == STOP) && w_baud_end)) begin
            w_buf_nxt      = w_word_ord;
            w_buf_full_nxt = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_buf      <= w_buf_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign tx              = r_tx;
    assign tx_ready        = ~r_buf_full;
    assign is_transmitting = r_busy;
    assign tx_done         = r_done;

endmodule

// File: doc/wide_uart_tx.md
WIDE_UART_TX -- requirements
Module: wide_uart_tx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 8000000, line bit rate in bit/s.
REQ-002 SHALL have parameter SYS_CLK_FREQ, default 128000000, clk frequency in Hz.
REQ-003 SHALL have parameter DATA_BITS, default 13, data bits per frame.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port transmit, input, 1, request to send tx_word.
REQ-007 SHALL have port tx_word, input, DATA_BITS, word to send.
REQ-008 SHALL have port tx, output, 1, serial line; idle high.
REQ-009 SHALL have port tx_ready, output, 1, high when the holding buffer can accept a word.
REQ-010 SHALL have port is_transmitting, output, 1, high while any frame bit is on the line.
REQ-011 SHALL have port tx_done, output, 1, one-cycle pulse at end of each stop bit.

Function
REQ-012 SHALL define DIV = SYS_CLK_FREQ/BAUD_RATE clocks per bit; elaboration SHALL fail if it is not an integer or is less than 2 (defaults: DIV=16).
REQ-013 SHALL frame each word as: 1 start bit (0), DATA_BITS data bits, 1 stop bit (1); each bit held exactly DIV clocks; frame = (DATA_BITS+2)*DIV clocks.
REQ-014 SHALL accept a word on an edge where transmit=1 and tx_ready=1; transmit while tx_ready=0 SHALL be ignored with no side effect.
REQ-015 SHALL contain a shift register plus a one-word holding buffer; tx_ready = holding buffer empty.
REQ-016 SHALL use states IDLE, START, DATA, STOP; IDLE->START on load; START->DATA after DIV clocks; DATA->STOP after DATA_BITS*DIV clocks; STOP->START if a word is available, else STOP->IDLE.
REQ-017 SHALL, when accepting in IDLE, load the shifter directly (buffer stays empty, tx_ready stays 1); tx SHALL be 0 from the first clock after the accept edge.
REQ-018 SHALL, when accepting while busy, store in the buffer; tx_ready SHALL be 0 from the next clock until the buffer moves to the shifter.
REQ-019 SHALL, at the end of STOP, start the next frame on the following clock with no idle gap, taking the buffered word if present, else a word accepted on that same edge.
REQ-020 SHALL drive tx, is_transmitting and tx_done from registers (no combinational path from inputs).
REQ-021 SHALL assert tx_done for exactly one clock, coincident with the last clock of the stop bit.

Reset
REQ-022 SHALL, on any edge with rst=0, set tx=1, tx_ready=1, is_transmitting=0, tx_done=0, state=IDLE, bit and baud counters=0.
REQ-023 SHALL, on reset mid-frame, abort the frame and discard the buffered word; no tx_done for the aborted frame.
REQ-024 SHALL ignore transmit while rst=0.

Configuration
REQ-025 SHALL, when macro WIDE_UART_TX_BITREV_EN is defined, send data bits MSB first (tx_word[DATA_BITS-1] first).
REQ-026 SHALL, when WIDE_UART_TX_BITREV_EN is undefined, send data bits LSB first (tx_word[0] first).

Verification
REQ-027 SHALL cover reset: hold rst=0 for 3 clocks mid-stimulus -> tx=1, tx_ready=1, is_transmitting=0, tx_done=0.
REQ-028 SHALL cover single frame, defaults, no macro: send 13'h1A5B -> 0, then 1,1,0,1,1,0,1,0,0,1,0,1,1, then 1, each bit 16 clocks; tx_done on clock 240 after accept.
REQ-029 SHALL cover back-to-back: accept 13'h0000, then 13'h1FFF one clock later -> tx_ready low from clock 2 until clock 240; second start bit begins clock 241; total 480 clocks, two tx_done pulses.
REQ-030 SHALL cover overflow: third transmit (13'h0AAA) while tx_ready=0 -> ignored; only two frames on the line.
REQ-031 SHALL cover reset during data bit 5 -> tx=1 on next clock; no tx_done; next accepted word sends a clean frame.
REQ-032 SHALL cover WIDE_UART_TX_BITREV_EN defined: send 13'h0001 -> start, twelve 0 bits, then 1, then stop.
